// File: rtl/decoder24_seq_if.sv
// Handshake and output bundle for decoder24_seq: upstream pushes 2-bit codes,
// downstream observes the one-hot word plus status.
interface decoder24_seq_if #(
  parameter int DEPTH = 2
) ();
  logic [1:0]              code;
  logic                    code_valid;
  logic                    code_ready;
  logic [3:0]              d;
  logic                    d_valid;
  logic                    busy;
  logic [$clog2(DEPTH):0]  fifo_level;

  modport master (
    output code, code_valid,
    input  code_ready, d, d_valid, busy, fifo_level
  );

  modport slave (
    input  code, code_valid,
    output code_ready, d, d_valid, busy, fifo_level
  );
endinterface

// File: rtl/decoder24_seq.sv
// Sequential 2-to-4 decoder: buffers codes in a small FIFO and replays each one
// as a one-hot pulse of PULSE_CYCLES cycles followed by an idle gap.
module decoder24_seq #(
  parameter int DEPTH        = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 1,
  parameter int CNT_W        = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  decoder24_seq_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    GAP   = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         d_q, d_d;
  logic               d_valid_q, d_valid_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [1:0]         mem_q [DEPTH];

  logic full, push, pop;

  // Ready depends only on the registered level, so a same-edge pop never frees a slot early.
  assign full = (level_q == LVL_W'(DEPTH));
  assign push = bus.code_valid && !full;
  assign pop  = (state_q == IDLE) && (level_q != '0);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    d_valid_d = d_valid_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        d_d       = 4'b0000;
        d_valid_d = 1'b0;
        if (pop) begin
          d_d       = 4'b0001 << mem_q[rd_ptr_q];
          d_valid_d = 1'b1;
          cnt_d     = CNT_W'(PULSE_CYCLES - 1);
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          d_d       = 4'b0000;
          d_valid_d = 1'b0;
          cnt_d     = CNT_W'(GAP_CYCLES - 1);
          state_d   = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        d_d       = 4'b0000;
        d_valid_d = 1'b0;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: begin
        // Unreachable encoding: fall back to a clean idle output.
        state_d   = IDLE;
        d_d       = 4'b0000;
        d_valid_d = 1'b0;
        cnt_d     = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
      state_q   <= IDLE;
      d_q       <= 4'b0000;
      d_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

  // NOTE: the storage array is not reset; level and pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.code;
  end

  assign bus.code_ready = !full;
  assign bus.d          = d_q;
  assign bus.d_valid    = d_valid_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_level = level_q;

endmodule

// File: tb/tb_decoder24_seq.sv
// Scoreboard bench for decoder24_seq: stimulus queues expected words, a negedge
// monitor pops and checks content, pulse length, gap length and invariants.
module tb_decoder24_seq;

  localparam int DEPTH = 2;
  localparam int PULSE = 4;

  typedef struct {
    logic [1:0] code;
    logic [3:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  decoder24_seq_if #(.DEPTH(DEPTH)) bus ();

  decoder24_seq #(
    .DEPTH(DEPTH), .PULSE_CYCLES(PULSE), .GAP_CYCLES(1), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder42: one-hot i1..i4 back to the 2-bit code.
  function automatic logic [1:0] enc42(input logic [3:0] w);
    case (w)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // ---------------- monitor ----------------
  exp_t cur;
  bit   prev_v, have_word, next_queued;
  int   run_len, gap_len;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v    = 1'b0;
      have_word = 1'b0;
      run_len   = 0;
      gap_len   = 0;
    end else begin
      check("inv_dvalid", {31'd0, bus.d_valid}, {31'd0, bus.d != 4'b0000});
      check("inv_onehot0", {31'd0, $onehot0(bus.d)}, 32'd1);
      if (bus.d_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {28'd0, bus.d}, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("word_d", {28'd0, bus.d}, {28'd0, cur.d});
          check("loopback_code", {30'd0, enc42(bus.d)}, {30'd0, cur.code});
        end
        if (have_word) begin
          check("min_gap", {31'd0, gap_len >= 2}, 32'd1);
          if (next_queued) check("gap_len", gap_len, 2);
        end
        have_word = 1'b1;
        run_len   = 1;
      end else if (bus.d_valid) begin
        check("hold_d", {28'd0, bus.d}, {28'd0, cur.d});
        run_len++;
      end else if (prev_v) begin
        check("pulse_len", run_len, PULSE);
        gap_len     = 1;
        next_queued = (bus.fifo_level != '0);
      end else begin
        gap_len++;
      end
      prev_v = bus.d_valid;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] c, input logic [3:0] exp_d);
    bit acc = 1'b0;
    int n   = 0;
    bus.code       = c;
    bus.code_valid = 1'b1;
    while (!acc && n < 100) begin
      acc = bus.code_ready;
      @(posedge clk);
      n++;
      if (acc) exp_q.push_back('{code: c, d: exp_d});
      #1;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    bus.code_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy || bus.d_valid || bus.fifo_level != '0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", {31'd0, n < 500}, 32'd1);
  endtask

  logic [1:0] sweep_code [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [3:0] sweep_d    [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  initial begin
    rst_n          = 1'b0;
    bus.code       = 2'b00;
    bus.code_valid = 1'b0;

    // Reset values, held across three cycles.
    repeat (3) begin
      @(negedge clk);
      check("rst_d",        {28'd0, bus.d},          32'd0);
      check("rst_dvalid",   {31'd0, bus.d_valid},    32'd0);
      check("rst_busy",     {31'd0, bus.busy},       32'd0);
      check("rst_level",    {30'd0, bus.fifo_level}, 32'd0);
      check("rst_ready",    {31'd0, bus.code_ready}, 32'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Single code: exact latency, pulse and gap timing.
    send(2'b10, 4'b0100);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check("t2_d",      {28'd0, bus.d},       (k <= 4) ? 32'h4 : 32'h0);
      check("t2_dvalid", {31'd0, bus.d_valid}, (k <= 4) ? 32'd1 : 32'd0);
      check("t2_busy",   {31'd0, bus.busy},    (k <= 5) ? 32'd1 : 32'd0);
    end
    wait_idle();

    // Sweep all four codes back-to-back.
    for (int i = 0; i < 4; i++) send(sweep_code[i], sweep_d[i]);
    wait_idle();

    // Fill the FIFO while DRIVE is active; third code must stall.
    send(2'b10, 4'b0100);
    @(posedge clk);
    #1;
    send(2'b11, 4'b1000);
    send(2'b00, 4'b0001);
    check("t4_ready_full", {31'd0, bus.code_ready}, 32'd0);
    check("t4_level_full", {30'd0, bus.fifo_level}, 32'd2);
    send(2'b01, 4'b0010);
    wait_idle();

    // Reset in the 2nd DRIVE cycle with one code queued.
    send(2'b10, 4'b0100);
    send(2'b11, 4'b1000);
    @(posedge clk);
    #1;
    check("t5_pre_level", {30'd0, bus.fifo_level}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("t5_d",      {28'd0, bus.d},          32'd0);
    check("t5_dvalid", {31'd0, bus.d_valid},    32'd0);
    check("t5_level",  {30'd0, bus.fifo_level}, 32'd0);
    check("t5_busy",   {31'd0, bus.busy},       32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(2'b01, 4'b0010);
    @(posedge clk);
    #1;
    check("t5_after_d", {28'd0, bus.d}, 32'h2);
    wait_idle();

    // Loopback through the reference encoder over randomised codes.
    for (int i = 0; i < 16; i++) begin
      logic [1:0] c;
      logic [3:0] one;
      c   = 2'($urandom_range(0, 3));
      one = 4'b0001;
      send(c, one << c);
    end
    wait_idle();

    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
